npc_fetch_decode_exec: RTL and testbench

Combinational fetch, decode and execute slice of the single-cycle RV32I NPC core. It presents the current PC to instruction memory and decodes the returned word into register, memory and next-PC control. It evaluates the ALU on register or immediate operands. The enclosing core supplies the PC register, register file, data memory and the next-PC/write-back muxes.

---
 rtl/npc_fetch_decode_exec.sv | 383 ++++++++++++++++++++++++++++++++++++++
 tb/tb_npc_fetch_decode_exec.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/npc_fetch_decode_exec.sv
// npc_fetch_decode_exec
//
// Combinational fetch / decode / execute slice of the single-cycle RV32I NPC core.
// The current PC goes straight out as the fetch address. The returned word is decoded
// into register, memory and next-PC control, and the ALU is evaluated on src1 and either
// src2 or the immediate. The only state is a sticky halt flag.
//
// Ports:
//   clk, rst          clock (halt flag only); synchronous active-high reset
//   pc                current PC
//   imem_addr         instruction fetch address (= pc)
//   imem_rdata        instruction word at imem_addr, same cycle
//   src1, src2        register file read data for rs1 / rs2
//   inst              instruction being executed (NOP while rst=1)
//   rs1, rs2, rd      register indices
//   imm               sign-extended immediate for the decoded format
//   imm_for_alu       ALU operand2 select: 1 imm, 0 src2
//   alu_opcode        selected ALU operation
//   alu_result, zero  ALU result and (alu_result == 0)
//   npc_sel           00 pc+4, 01 pc+imm, 10 alu_result&~1, 11 zero ? pc+4 : pc+imm
//   reg_wen           register write enable (never set for rd == 0)
//   reg_wdata_sel     00 alu_result, 01 pc+4, 10 pc+imm, 11 load data
//   mem_ren, mem_wen  data memory read / write enables
//   mem_size          00 byte, 01 half, 10 word
//   mem_unsigned      load zero-extends
//   illegal           encoding not decoded
//   halt              EBREAK seen (sticky until rst)
//
// Configuration macro: ILLEGAL_HALT_EN -- when defined, an illegal instruction also
// halts the core; otherwise it is only flagged and executes as a NOP.

module npc_fetch_decode_exec (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] inst,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        imm_for_alu,
    output logic [4:0]  alu_opcode,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [1:0]  npc_sel,
    output logic        reg_wen,
    output logic [1:0]  reg_wdata_sel,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic        illegal,
    output logic        halt
);

    localparam logic [31:0] InstNop    = 32'h0000_0013;
    localparam logic [31:0] InstEbreak = 32'h0010_0073;
    localparam logic [31:0] InstEcall  = 32'h0000_0073;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcFence  = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    typedef enum logic [4:0] {
        AluAdd   = 5'd0,
        AluSub   = 5'd1,
        AluAnd   = 5'd2,
        AluOr    = 5'd3,
        AluXor   = 5'd4,
        AluSll   = 5'd5,
        AluSrl   = 5'd6,
        AluSra   = 5'd7,
        AluSlt   = 5'd8,
        AluSltu  = 5'd9,
        AluPassb = 5'd10,
        AluEq    = 5'd11,
        AluNe    = 5'd12,
        AluLt    = 5'd13,
        AluGe    = 5'd14,
        AluLtu   = 5'd15,
        AluGeu   = 5'd16
    } alu_op_e;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    alu_op_e     alu_op;
    logic        wen_raw;
    logic        ebreak;
    logic        halt_comb;
    logic        halt_q;
    logic        halt_d;
    logic [31:0] op2;

    // ------------------------------------------------------------------
    // Fetch
    // ------------------------------------------------------------------
    assign imem_addr = pc;
    // Holding a NOP during reset keeps every enable low without extra gating.
    assign inst   = rst ? InstNop : imem_rdata;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    // ------------------------------------------------------------------
    // Immediate generation
    // ------------------------------------------------------------------
    always_comb begin
        imm = 32'h0;
        case (opcode)
            OpcOpImm, OpcJalr, OpcLoad, OpcFence, OpcSystem: begin
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            OpcStore: begin
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OpcBranch: begin
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OpcLui, OpcAuipc: begin
                imm = {inst[31:12], 12'h000};
            end
            OpcJal: begin
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: imm = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    always_comb begin
        alu_op        = AluAdd;
        imm_for_alu   = 1'b0;
        npc_sel       = 2'b00;
        wen_raw       = 1'b0;
        reg_wdata_sel = 2'b00;
        mem_ren       = 1'b0;
        mem_wen       = 1'b0;
        mem_size      = 2'b00;
        mem_unsigned  = 1'b0;
        illegal       = 1'b0;
        ebreak        = 1'b0;

        case (opcode)
            OpcOp: begin
                wen_raw = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            alu_op = AluAdd;
                        end else if (funct7 == 7'b0100000) begin
                            alu_op = AluSub;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    3'b001: begin
                        alu_op  = AluSll;
                        illegal = (funct7 != 7'b0000000);
                    end
                    3'b010: begin
                        alu_op  = AluSlt;
                        illegal = (funct7 != 7'b0000000);
                    end
                    3'b011: begin
                        alu_op  = AluSltu;
                        illegal = (funct7 != 7'b0000000);
                    end
                    3'b100: begin
                        alu_op  = AluXor;
                        illegal = (funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin
                            alu_op = AluSrl;
                        end else if (funct7 == 7'b0100000) begin
                            alu_op = AluSra;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    3'b110: begin
                        alu_op  = AluOr;
                        illegal = (funct7 != 7'b0000000);
                    end
                    default: begin
                        alu_op  = AluAnd;
                        illegal = (funct7 != 7'b0000000);
                    end
                endcase
            end
            OpcOpImm: begin
                wen_raw     = 1'b1;
                imm_for_alu = 1'b1;
                case (funct3)
                    3'b000: alu_op = AluAdd;
                    3'b010: alu_op = AluSlt;
                    3'b011: alu_op = AluSltu;
                    3'b100: alu_op = AluXor;
                    3'b110: alu_op = AluOr;
                    3'b111: alu_op = AluAnd;
                    3'b001: begin
                        alu_op  = AluSll;
                        illegal = (funct7 != 7'b0000000);
                    end
                    default: begin
                        // SRAI keeps imm[10] set; the shifter only uses operand2[4:0].
                        if (funct7 == 7'b0000000) begin
                            alu_op = AluSrl;
                        end else if (funct7 == 7'b0100000) begin
                            alu_op = AluSra;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                endcase
            end
            OpcLui: begin
                wen_raw     = 1'b1;
                imm_for_alu = 1'b1;
                alu_op      = AluPassb;
            end
            OpcAuipc: begin
                wen_raw       = 1'b1;
                imm_for_alu   = 1'b1;
                reg_wdata_sel = 2'b10;
            end
            OpcJal: begin
                wen_raw       = 1'b1;
                npc_sel       = 2'b01;
                reg_wdata_sel = 2'b01;
            end
            OpcJalr: begin
                // funct3 is not checked: any JALR encoding jumps to src1 + imm.
                wen_raw       = 1'b1;
                imm_for_alu   = 1'b1;
                alu_op        = AluAdd;
                npc_sel       = 2'b10;
                reg_wdata_sel = 2'b01;
            end
            OpcBranch: begin
                npc_sel = 2'b11;
                case (funct3)
                    3'b000: alu_op = AluEq;
                    3'b001: alu_op = AluNe;
                    3'b100: alu_op = AluLt;
                    3'b101: alu_op = AluGe;
                    3'b110: alu_op = AluLtu;
                    3'b111: alu_op = AluGeu;
                    default: begin
                        npc_sel = 2'b00;
                        illegal = 1'b1;
                    end
                endcase
            end
            OpcLoad: begin
                imm_for_alu = 1'b1;
                alu_op      = AluAdd;
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
                        wen_raw       = 1'b1;
                        mem_ren       = 1'b1;
                        reg_wdata_sel = 2'b11;
                        mem_size      = funct3[1:0];
                        mem_unsigned  = funct3[2];
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OpcStore: begin
                imm_for_alu = 1'b1;
                alu_op      = AluAdd;
                case (funct3)
                    3'b000, 3'b001, 3'b010: begin
                        mem_wen  = 1'b1;
                        mem_size = funct3[1:0];
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OpcFence: begin
                illegal = (funct3 != 3'b000);
            end
            OpcSystem: begin
                if (inst == InstEbreak) begin
                    ebreak = 1'b1;
                end else if (inst != InstEcall) begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        // An undecoded encoding must not leave any side effect behind.
        if (illegal) begin
            alu_op        = AluAdd;
            imm_for_alu   = 1'b0;
            npc_sel       = 2'b00;
            wen_raw       = 1'b0;
            reg_wdata_sel = 2'b00;
            mem_ren       = 1'b0;
            mem_wen       = 1'b0;
            mem_size      = 2'b00;
            mem_unsigned  = 1'b0;
        end
    end

    assign reg_wen    = wen_raw && (rd != 5'd0);
    assign alu_opcode = alu_op;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign op2 = imm_for_alu ? imm : src2;

    always_comb begin
        alu_result = 32'h0;
        case (alu_opcode)
            AluAdd:   alu_result = src1 + op2;
            AluSub:   alu_result = src1 - op2;
            AluAnd:   alu_result = src1 & op2;
            AluOr:    alu_result = src1 | op2;
            AluXor:   alu_result = src1 ^ op2;
            AluSll:   alu_result = src1 << op2[4:0];
            AluSrl:   alu_result = src1 >> op2[4:0];
            AluSra:   alu_result = $unsigned($signed(src1) >>> op2[4:0]);
            AluSlt:   alu_result = {31'h0, $signed(src1) < $signed(op2)};
            AluSltu:  alu_result = {31'h0, src1 < op2};
            AluPassb: alu_result = op2;
            AluEq:    alu_result = {31'h0, src1 == op2};
            AluNe:    alu_result = {31'h0, src1 != op2};
            AluLt:    alu_result = {31'h0, $signed(src1) < $signed(op2)};
            AluGe:    alu_result = {31'h0, $signed(src1) >= $signed(op2)};
            AluLtu:   alu_result = {31'h0, src1 < op2};
            AluGeu:   alu_result = {31'h0, src1 >= op2};
            default:  alu_result = 32'h0;
        endcase
    end

    assign zero = (alu_result == 32'h0);

    // ------------------------------------------------------------------
    // Halt
    // ------------------------------------------------------------------
`ifdef ILLEGAL_HALT_EN
    assign halt_comb = ebreak | illegal;
`else
    assign halt_comb = ebreak;
`endif

    always_comb begin
        halt_d = halt_q | halt_comb;
        if (rst) begin
            halt_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        halt_q <= halt_d;
    end

    // halt_q may still hold a stale 1 during the reset cycle, so mask it with rst.
    assign halt = !rst && (halt_comb || halt_q);

endmodule

// File: tb/tb_npc_fetch_decode_exec.sv
module tb_npc_fetch_decode_exec;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        imm_for_alu;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        zero;
    logic [1:0]  npc_sel;
    logic        reg_wen;
    logic [1:0]  reg_wdata_sel;
    logic        mem_ren;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        illegal;
    logic        halt;

    int passed;
    int total;

    npc_fetch_decode_exec dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .src1         (src1),
        .src2         (src2),
        .inst         (inst),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .imm          (imm),
        .imm_for_alu  (imm_for_alu),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .zero         (zero),
        .npc_sel      (npc_sel),
        .reg_wen      (reg_wen),
        .reg_wdata_sel(reg_wdata_sel),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .illegal      (illegal),
        .halt         (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic apply(input logic r, input logic [31:0] w, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        rst        = r;
        imem_rdata = w;
        src1       = a;
        src2       = b;
        #1;
    endtask

    task automatic test_reset();
        pc = 32'h8000_0000;
        apply(1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0);
        total++; if (inst !== 32'h0000_0013) $display("FAIL reset_inst got %h want 00000013", inst); else passed++;
        total++; if (reg_wen !== 1'b0) $display("FAIL reset_reg_wen got %b want 0", reg_wen); else passed++;
        total++; if (mem_wen !== 1'b0) $display("FAIL reset_mem_wen got %b want 0", mem_wen); else passed++;
        total++; if (halt !== 1'b0) $display("FAIL reset_halt got %b want 0", halt); else passed++;
        total++; if (npc_sel !== 2'b00) $display("FAIL reset_npc_sel got %b want 00", npc_sel); else passed++;
        total++; if (imem_addr !== 32'h8000_0000) $display("FAIL reset_imem_addr got %h want 80000000", imem_addr); else passed++;
        apply(1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0);
    endtask

    task automatic test_addi();
        pc = 32'h0000_1000;
        apply(1'b0, 32'h0050_0093, 32'h0, 32'h0);
        total++; if (imem_addr !== 32'h0000_1000) $display("FAIL addi_imem_addr got %h want 00001000", imem_addr); else passed++;
        total++; if (rd !== 5'd1) $display("FAIL addi_rd got %0d want 1", rd); else passed++;
        total++; if (imm !== 32'd5) $display("FAIL addi_imm got %h want 5", imm); else passed++;
        total++; if (imm_for_alu !== 1'b1) $display("FAIL addi_imm_for_alu got %b want 1", imm_for_alu); else passed++;
        total++; if (alu_result !== 32'd5) $display("FAIL addi_alu got %h want 5", alu_result); else passed++;
        total++; if (reg_wen !== 1'b1) $display("FAIL addi_reg_wen got %b want 1", reg_wen); else passed++;
        total++; if (npc_sel !== 2'b00) $display("FAIL addi_npc_sel got %b want 00", npc_sel); else passed++;
        total++; if (reg_wdata_sel !== 2'b00) $display("FAIL addi_wdata_sel got %b want 00", reg_wdata_sel); else passed++;
        total++; if (illegal !== 1'b0) $display("FAIL addi_illegal got %b want 0", illegal); else passed++;
        // addi x0,x0,1: write to x0 is suppressed
        apply(1'b0, 32'h0010_0013, 32'h0, 32'h0);
        total++; if (reg_wen !== 1'b0) $display("FAIL addi_x0_reg_wen got %b want 0", reg_wen); else passed++;
    endtask

    task automatic test_sub();
        apply(1'b0, 32'h4020_8133, 32'd10, 32'd3);
        total++; if (rd !== 5'd2 || rs1 !== 5'd1 || rs2 !== 5'd2)
            $display("FAIL sub_regs got rd=%0d rs1=%0d rs2=%0d want 2 1 2", rd, rs1, rs2); else passed++;
        total++; if (alu_opcode !== 5'd1) $display("FAIL sub_opcode got %0d want 1", alu_opcode); else passed++;
        total++; if (imm_for_alu !== 1'b0) $display("FAIL sub_imm_for_alu got %b want 0", imm_for_alu); else passed++;
        total++; if (alu_result !== 32'd7) $display("FAIL sub_alu got %h want 7", alu_result); else passed++;
        total++; if (zero !== 1'b0) $display("FAIL sub_zero_a got %b want 0", zero); else passed++;
        apply(1'b0, 32'h4020_8133, 32'd3, 32'd3);
        total++; if (alu_result !== 32'd0) $display("FAIL sub_alu_eq got %h want 0", alu_result); else passed++;
        total++; if (zero !== 1'b1) $display("FAIL sub_zero_b got %b want 1", zero); else passed++;
    endtask

    task automatic test_shift_lui();
        // srai x1,x1,4
        apply(1'b0, 32'h4040_D093, 32'h8000_0000, 32'h0);
        total++; if (alu_opcode !== 5'd7) $display("FAIL srai_opcode got %0d want 7", alu_opcode); else passed++;
        total++; if (alu_result !== 32'hF800_0000) $display("FAIL srai_alu got %h want f8000000", alu_result); else passed++;
        // lui x1,0x12345
        apply(1'b0, 32'h1234_50B7, 32'hDEAD_BEEF, 32'h0);
        total++; if (imm !== 32'h1234_5000) $display("FAIL lui_imm got %h want 12345000", imm); else passed++;
        total++; if (alu_result !== 32'h1234_5000) $display("FAIL lui_alu got %h want 12345000", alu_result); else passed++;
        total++; if (alu_opcode !== 5'd10) $display("FAIL lui_opcode got %0d want 10", alu_opcode); else passed++;
    endtask

    task automatic test_branch();
        apply(1'b0, 32'h0020_8463, 32'd7, 32'd7);
        total++; if (npc_sel !== 2'b11) $display("FAIL beq_npc_sel got %b want 11", npc_sel); else passed++;
        total++; if (imm !== 32'd8) $display("FAIL beq_imm got %h want 8", imm); else passed++;
        total++; if (zero !== 1'b0) $display("FAIL beq_taken_zero got %b want 0", zero); else passed++;
        total++; if (alu_result !== 32'd1) $display("FAIL beq_taken_alu got %h want 1", alu_result); else passed++;
        total++; if (reg_wen !== 1'b0) $display("FAIL beq_reg_wen got %b want 0", reg_wen); else passed++;
        total++; if (alu_opcode !== 5'd11) $display("FAIL beq_opcode got %0d want 11", alu_opcode); else passed++;
        apply(1'b0, 32'h0020_8463, 32'd7, 32'd6);
        total++; if (zero !== 1'b1) $display("FAIL beq_not_taken_zero got %b want 1", zero); else passed++;
    endtask

    task automatic test_load_store_jalr();
        apply(1'b0, 32'hFFC0_A183, 32'h8000_0010, 32'h0);
        total++; if (imm !== 32'hFFFF_FFFC) $display("FAIL lw_imm got %h want fffffffc", imm); else passed++;
        total++; if (alu_result !== 32'h8000_000C) $display("FAIL lw_alu got %h want 8000000c", alu_result); else passed++;
        total++; if (mem_ren !== 1'b1) $display("FAIL lw_mem_ren got %b want 1", mem_ren); else passed++;
        total++; if (mem_size !== 2'b10) $display("FAIL lw_mem_size got %b want 10", mem_size); else passed++;
        total++; if (reg_wdata_sel !== 2'b11) $display("FAIL lw_wdata_sel got %b want 11", reg_wdata_sel); else passed++;
        total++; if (reg_wen !== 1'b1 || rd !== 5'd3) $display("FAIL lw_wen_rd got %b/%0d want 1/3", reg_wen, rd); else passed++;
        total++; if (mem_wen !== 1'b0) $display("FAIL lw_mem_wen got %b want 0", mem_wen); else passed++;
        // sw x2,8(x1)
        apply(1'b0, 32'h0020_A423, 32'h0000_0100, 32'h55);
        total++; if (alu_result !== 32'h0000_0108) $display("FAIL sw_alu got %h want 00000108", alu_result); else passed++;
        total++; if (mem_wen !== 1'b1 || mem_ren !== 1'b0) $display("FAIL sw_mem_en got wen=%b ren=%b want 1 0", mem_wen, mem_ren); else passed++;
        total++; if (reg_wen !== 1'b0) $display("FAIL sw_reg_wen got %b want 0", reg_wen); else passed++;
        apply(1'b0, 32'h0000_F0E7, 32'h8000_0011, 32'h0);
        total++; if (npc_sel !== 2'b10) $display("FAIL jalr_npc_sel got %b want 10", npc_sel); else passed++;
        total++; if (alu_result !== 32'h8000_0011) $display("FAIL jalr_alu got %h want 80000011", alu_result); else passed++;
        total++; if (reg_wdata_sel !== 2'b01) $display("FAIL jalr_wdata_sel got %b want 01", reg_wdata_sel); else passed++;
        total++; if (reg_wen !== 1'b1) $display("FAIL jalr_reg_wen got %b want 1", reg_wen); else passed++;
    endtask

    task automatic test_halt();
        apply(1'b0, 32'h0010_0073, 32'h0, 32'h0);
        total++; if (halt !== 1'b1) $display("FAIL ebreak_halt got %b want 1", halt); else passed++;
        total++; if (reg_wen !== 1'b0 || illegal !== 1'b0)
            $display("FAIL ebreak_ctrl got wen=%b illegal=%b want 0 0", reg_wen, illegal); else passed++;
        apply(1'b0, 32'h0000_0013, 32'h0, 32'h0);
        total++; if (halt !== 1'b1) $display("FAIL halt_sticky_1 got %b want 1", halt); else passed++;
        apply(1'b0, 32'h0000_0013, 32'h0, 32'h0);
        apply(1'b0, 32'h0000_0013, 32'h0, 32'h0);
        total++; if (halt !== 1'b1) $display("FAIL halt_sticky_3 got %b want 1", halt); else passed++;
        apply(1'b1, 32'h0000_0013, 32'h0, 32'h0);
        total++; if (halt !== 1'b0) $display("FAIL halt_in_reset got %b want 0", halt); else passed++;
        apply(1'b0, 32'h0000_0013, 32'h0, 32'h0);
        total++; if (halt !== 1'b0) $display("FAIL halt_cleared got %b want 0", halt); else passed++;
        // Reset wins over an EBREAK on the bus
        apply(1'b1, 32'h0010_0073, 32'h0, 32'h0);
        total++; if (halt !== 1'b0 || inst !== 32'h0000_0013)
            $display("FAIL reset_vs_ebreak got halt=%b inst=%h want 0 00000013", halt, inst); else passed++;
        apply(1'b0, 32'h0000_0013, 32'h0, 32'h0);
        total++; if (halt !== 1'b0) $display("FAIL reset_vs_ebreak_after got %b want 0", halt); else passed++;
    endtask

    task automatic test_illegal();
        logic exp_halt;
`ifdef ILLEGAL_HALT_EN
        exp_halt = 1'b1;
`else
        exp_halt = 1'b0;
`endif
        apply(1'b0, 32'hFFFF_FFFF, 32'h1, 32'h2);
        total++; if (illegal !== 1'b1) $display("FAIL illegal_flag got %b want 1", illegal); else passed++;
        total++; if (reg_wen !== 1'b0 || mem_wen !== 1'b0 || mem_ren !== 1'b0 || npc_sel !== 2'b00)
            $display("FAIL illegal_ctrl got wen=%b mw=%b mr=%b npc=%b want 0 0 0 00",
                     reg_wen, mem_wen, mem_ren, npc_sel); else passed++;
        total++; if (halt !== exp_halt) $display("FAIL illegal_halt got %b want %b", halt, exp_halt); else passed++;
        apply(1'b0, 32'h0000_0013, 32'h0, 32'h0);
        total++; if (halt !== exp_halt) $display("FAIL illegal_halt_after got %b want %b", halt, exp_halt); else passed++;
        apply(1'b1, 32'h0000_0013, 32'h0, 32'h0);
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        rst        = 1'b1;
        pc         = 32'h0;
        imem_rdata = 32'h0;
        src1       = 32'h0;
        src2       = 32'h0;
        test_reset();
        test_addi();
        test_sub();
        test_shift_lui();
        test_branch();
        test_load_store_jalr();
        test_halt();
        test_illegal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
